// File: rtl/wtm_pkg.sv
// wtm_pkg: tree-shape math and Baugh-Wooley helpers
// shared by the pipelined Wallace-tree multiplier.
package wtm_pkg;

  function automatic int wtm_next_rows(int rows);
    return 2 * (rows / 3) + rows % 3;
  endfunction

  function automatic int wtm_tree_depth(int rows);
    int n;
    int d;
    n = rows;
    d = 0;
    while (n > 2) begin
      n = wtm_next_rows(n);
      d++;
    end
    return d;
  endfunction

  function automatic int wtm_rows_at(int rows, int lyr);
    int n;
    n = rows;
    for (int i = 0; i < lyr; i++)
      n = wtm_next_rows(n);
    return n;
  endfunction

  // Baugh-Wooley fix-up: +2^w and +2^(2w-1)
  function automatic logic [63:0] wtm_bw_corr(int w);
    return (64'd1 << w) | (64'd1 << (2 * w - 1));
  endfunction

endpackage

// File: rtl/csa_3to2.sv
// csa_3to2: N-bit carry-save row, three rows in,
// sum and shifted carry out, top carry dropped.
module csa_3to2
  import wtm_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic [N-1:0] i_c,
  output logic [N-1:0] o_sum,
  output logic [N-1:0] o_carry
);

  assign o_sum = i_a ^ i_b ^ i_c;

  assign o_carry = {
    (i_a[N-2:0] & i_b[N-2:0]) |
    (i_a[N-2:0] & i_c[N-2:0]) |
    (i_b[N-2:0] & i_c[N-2:0]),
    1'b0
  };

endmodule

// File: rtl/wallace_mult_pipe.sv
// wallace_mult_pipe: 3-stage W x W Wallace multiplier, full 2W product.
// Define WTM_SIGNED_EN to add the in_signed port (Baugh-Wooley mode).
module wallace_mult_pipe
  import wtm_pkg::*;
#(
  parameter int W     = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [TAG_W-1:0] in_tag,
`ifdef WTM_SIGNED_EN
  input  logic             in_signed,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_p,
  output logic [TAG_W-1:0] out_tag
);

  typedef logic [2*W-1:0] row_t;

`ifdef WTM_SIGNED_EN
  localparam int NR = W + 1;
`else
  localparam int NR = W;
`endif
  localparam int D = wtm_tree_depth(NR);
  localparam logic [W-1:0] MSB = W'(1) << (W - 1);

  logic             w_adv;
  logic             w_sgn;
  row_t             w_pp [W];
  row_t             w_x;
  row_t             w_y;

  logic             r_s1_v;
  row_t             r_s1_pp [W];
  logic [TAG_W-1:0] r_s1_tag;
  logic             r_s2_v;
  row_t             r_s2_x;
  row_t             r_s2_y;
  logic [TAG_W-1:0] r_s2_tag;
  logic             r_s3_v;
  row_t             r_s3_p;
  logic [TAG_W-1:0] r_s3_tag;

`ifdef WTM_SIGNED_EN
  logic             r_s1_sgn;
  assign w_sgn = in_signed;
`else
  assign w_sgn = 1'b0;
`endif

  assign w_adv     = !r_s3_v || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_s3_v;
  assign out_p     = r_s3_p;
  assign out_tag   = r_s3_tag;

  // Signed rows flip the a[W-1]*b[j] / a[i]*b[W-1] terms
  always_comb begin
    for (int j = 0; j < W; j++) begin
      w_pp[j] = row_t'(in_a & {W{in_b[j]}}) << j;
      if (w_sgn)
        w_pp[j] = row_t'((in_a & {W{in_b[j]}}) ^
                  (j == W - 1 ? ~MSB : MSB)) << j;
    end
  end

  for (genvar l = 0; l <= D; l++) begin : g_lyr
    localparam int N = wtm_rows_at(NR, l);
    row_t w_row [N];
    if (l == 0) begin : g_src
      for (genvar r = 0; r < W; r++) begin : g_r
        assign w_row[r] = r_s1_pp[r];
      end
`ifdef WTM_SIGNED_EN
      assign w_row[W] = r_s1_sgn ? row_t'(wtm_bw_corr(W)) : '0;
`endif
    end else begin : g_red
      localparam int M = wtm_rows_at(NR, l - 1);
      for (genvar g = 0; g < M / 3; g++) begin : g_csa
        csa_3to2 #(.N(2 * W)) u_csa (
          .i_a    (g_lyr[l-1].w_row[3*g]),
          .i_b    (g_lyr[l-1].w_row[3*g+1]),
          .i_c    (g_lyr[l-1].w_row[3*g+2]),
          .o_sum  (w_row[2*g]),
          .o_carry(w_row[2*g+1])
        );
      end
      for (genvar k = 0; k < M % 3; k++) begin : g_pass
        assign w_row[2*(M/3)+k] = g_lyr[l-1].w_row[3*(M/3)+k];
      end
    end
  end

  assign w_x = g_lyr[D].w_row[0];
  assign w_y = g_lyr[D].w_row[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_v   <= 1'b0;
      r_s1_pp  <= '{default: '0};
      r_s1_tag <= '0;
      r_s2_v   <= 1'b0;
      r_s2_x   <= '0;
      r_s2_y   <= '0;
      r_s2_tag <= '0;
      r_s3_v   <= 1'b0;
      r_s3_p   <= '0;
      r_s3_tag <= '0;
`ifdef WTM_SIGNED_EN
      r_s1_sgn <= 1'b0;
`endif
    end else if (w_adv) begin
      r_s1_v   <= in_valid;
      r_s1_pp  <= w_pp;
      r_s1_tag <= in_tag;
      r_s2_v   <= r_s1_v;
      r_s2_x   <= w_x;
      r_s2_y   <= w_y;
      r_s2_tag <= r_s1_tag;
      r_s3_v   <= r_s2_v;
      r_s3_p   <= r_s2_x + r_s2_y;
      r_s3_tag <= r_s2_tag;
`ifdef WTM_SIGNED_EN
      r_s1_sgn <= in_signed;
`endif
    end
  end

endmodule
